axi_lite_mem_reader: RTL

- AXI-Lite read-channel master that sits upstream of the CPU's AXI-Lite read slave and drives its AR channel and R channel.
- On a start pulse it walks a word-aligned address range in data memory, one outstanding read at a time.
- Each returned word is presented on a valid/ready output stream toward a host-side consumer (UART dumper, debug FIFO).
- Used to dump CPU results from data memory after a run.

---
 rtl/axi_mem_reader_pkg.sv | 14 +
 rtl/axi_lite_mem_reader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/axi_mem_reader_pkg.sv
// Shared types and constants for the AXI-Lite memory reader.
package axi_mem_reader_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/axi_lite_mem_reader.sv
// AXI-Lite read master: walks a word range, one outstanding read, streams each word out.
// Optional running checksum of streamed words when MEM_READER_CHECKSUM_EN is defined.
module axi_lite_mem_reader
  import axi_mem_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MEM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;

  // The address register is only updated outside AR, so araddr is stable while arvalid is high.
  assign m_axi_araddr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      out_data      <= '0;
      out_addr      <= '0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
`ifdef MEM_READER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef MEM_READER_CHECKSUM_EN
            checksum <= '0;
`endif
            if (word_count != '0) begin
              addr          <= base_addr & ALIGN_MASK;
              remaining     <= word_count;
              m_axi_arvalid <= 1'b1;
              state         <= AR;
            end else begin
              state <= DONE;
            end
          end
        end

        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= R;
          end
        end

        R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            out_data     <= m_axi_rdata;
            out_addr     <= addr;
            out_last     <= (remaining == CNT_ONE);
            out_valid    <= 1'b1;
            state        <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - CNT_ONE;
            addr      <= addr + ADDR_STEP;
`ifdef MEM_READER_CHECKSUM_EN
            checksum  <= checksum + out_data;
`endif
            if (remaining == CNT_ONE) begin
              state <= DONE;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= AR;
            end
          end
        end

        // done is registered here, so it pulses in the cycle that busy falls
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
